// File: rtl/sha3_perm_ctrl.sv
// Sequencing controller for the Keccak-f[1600] round datapath: block absorb, round stepping, digest handshake.
// Optional permutation counter is built only when SHA3_PERF_CNT_EN is defined.
module sha3_perm_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int RND_W      = 5,
    parameter int PCNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              absorb_en,
    output logic              clear_state,
    output logic              round_en,
    output logic [RND_W-1:0]  round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              perm_done,
    output logic [PCNT_W-1:0] perm_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PERMUTE = 2'd1,
        SQUEEZE = 2'd2
    } state_t;

    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS - 1);

    state_t           state_q, state_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = '0;
        first_d     = first_q;
        last_d      = last_q;
        in_ready    = 1'b0;
        absorb_en   = 1'b0;
        clear_state = 1'b0;
        round_en    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        perm_done   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    absorb_en   = 1'b1;
                    clear_state = first_q;
                    last_d      = in_last;
                    first_d     = 1'b0;
                    state_d     = PERMUTE;
                end
            end
            PERMUTE: begin
                round_en = 1'b1;
                busy     = 1'b1;
                if (round_q == RND_LAST) begin
                    perm_done = 1'b1;
                    state_d   = last_q ? SQUEEZE : IDLE;
                end else begin
                    round_d = round_q + RND_W'(1);
                end
            end
            SQUEEZE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    first_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign round = round_q;

`ifdef SHA3_PERF_CNT_EN
    logic [PCNT_W-1:0] perm_count_q;

    // Saturates at all-ones so a long run never wraps back to a small count.
    always_ff @(posedge clk) begin
        if (reset) begin
            perm_count_q <= '0;
        end else if (perm_done && !(&perm_count_q)) begin
            perm_count_q <= perm_count_q + PCNT_W'(1);
        end
    end

    assign perm_count = perm_count_q;
`else
    assign perm_count = '0;
`endif

endmodule

// File: tb/tb_sha3_perm_ctrl.sv
// Self-checking bench for sha3_perm_ctrl: directed scenarios plus random traffic against a timeline model.
module tb_sha3_perm_ctrl;

    localparam int NR = 24;
    localparam int RW = 5;
    localparam int PW = 4;
    localparam int CNT_MAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, absorb_en, clear_state, round_en, out_valid, busy, perm_done;
    logic [RW-1:0] round;
    logic [PW-1:0] perm_count;

    always #5 clk = ~clk;

    sha3_perm_ctrl #(.NUM_ROUNDS(NR), .RND_W(RW), .PCNT_W(PW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .absorb_en(absorb_en), .clear_state(clear_state),
        .round_en(round_en), .round(round), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .perm_done(perm_done),
        .perm_count(perm_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a message block accepted at cycle t_acc occupies
    // cycles t_acc+1 .. t_acc+NR with rounds 0..NR-1; a last block then
    // holds the digest until the consumer takes it.
    int t     = 0;
    int t_acc = -1000;
    bit m_last = 1'b0;
    bit m_sq = 1'b0;
    bit m_first = 1'b1;
    int m_cnt = 0;

    task automatic step(input bit v, input bit l, input bit r, input bit rs, input bit chk);
        bit perm, idle, sq_now;
        int rnd, exp_cnt;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        reset     = rs;
        @(negedge clk);
        perm   = (t >= t_acc + 1) && (t <= t_acc + NR);
        rnd    = perm ? (t - t_acc - 1) : 0;
        sq_now = m_sq;
        idle   = !perm && !sq_now;
`ifdef SHA3_PERF_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        if (chk) begin
            check("in_ready",    32'(in_ready),    32'(idle));
            check("absorb_en",   32'(absorb_en),   32'(idle && v));
            check("clear_state", 32'(clear_state), 32'(idle && v && m_first));
            check("round_en",    32'(round_en),    32'(perm));
            check("round",       32'(round),       32'(rnd));
            check("out_valid",   32'(out_valid),   32'(sq_now));
            check("busy",        32'(busy),        32'(!idle));
            check("perm_done",   32'(perm_done),   32'(perm && rnd == NR - 1));
            check("perm_count",  32'(perm_count),  32'(exp_cnt));
        end
        if (rs) begin
            t_acc   = -1000;
            m_sq    = 1'b0;
            m_first = 1'b1;
            m_cnt   = 0;
        end else begin
            if (idle && v) begin
                t_acc   = t;
                m_last  = l;
                m_first = 1'b0;
            end
            if (perm && rnd == NR - 1) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (m_last) m_sq = 1'b1;
            end
            if (sq_now && r) begin
                m_sq    = 1'b0;
                m_first = 1'b1;
            end
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);

        // single-block message with immediate digest acceptance
        step(1, 1, 1, 0, 1);
        repeat (NR) step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);

        // two-block message, then 10 cycles of digest backpressure
        step(1, 0, 0, 0, 1);
        repeat (NR) step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        repeat (NR) step(0, 0, 0, 0, 1);
        repeat (10) step(1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 1);

        // reset while round==10, then next block must clear the state
        step(1, 0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1);
        repeat (NR) step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);

        // in_valid held high during a permutation: single absorb at IDLE
        step(1, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        repeat (NR + 4) step(1, 1, 1, 0, 1);
        repeat (NR) step(0, 0, 1, 0, 1);

        // back-to-back single-block messages, driving the counter into saturation
        repeat (18) begin
            step(1, 1, 1, 0, 1);
            repeat (NR + 1) step(0, 0, 1, 0, 1);
        end

        // random traffic with occasional resets
        repeat (3000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 399) == 0), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
